// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall and PC/branch flushes.
// Define HAZARD_PERF_EN to build the saturating stall/flush counters; otherwise they read zero.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        PCSrcD,
  input  logic        BranchD,
  input  logic        CondExE,
  input  logic        Match_1E_M,
  input  logic        Match_1E_W,
  input  logic        Match_2E_M,
  input  logic        Match_2E_W,
  input  logic        Match_12D_E,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        BranchTakenE,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic [15:0] LdStallCnt,
  output logic [15:0] FlushCnt
);

  logic RegWriteE, MemtoRegE, PCSrcE, BranchE;
  logic RegWriteM, MemtoRegM, PCSrcM;
  logic LDRstall, PCWrPendingF;
  logic branch_taken, flush_e_raw, flush_d_raw;
  logic [1:0] fwd_a, fwd_b;

  // Raw hazard terms depend only on registered state and inputs, so the
  // flush feeding the E-stage registers forms no combinational loop.
  assign branch_taken = BranchE & CondExE;
  assign LDRstall     = Match_12D_E & MemtoRegE & RegWriteE;
  assign PCWrPendingF = PCSrcD | PCSrcE | PCSrcM;
  assign flush_e_raw  = LDRstall | branch_taken;
  assign flush_d_raw  = PCWrPendingF | PCSrcW | branch_taken;

  always_comb begin
    fwd_a = 2'b00;
    if (Match_1E_M & RegWriteM)      fwd_a = 2'b10;
    else if (Match_1E_W & RegWriteW) fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (Match_2E_M & RegWriteM)      fwd_b = 2'b10;
    else if (Match_2E_W & RegWriteW) fwd_b = 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
      BranchE   <= 1'b0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      PCSrcM    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      if (flush_e_raw) begin
        RegWriteE <= 1'b0;
        MemtoRegE <= 1'b0;
        PCSrcE    <= 1'b0;
        BranchE   <= 1'b0;
      end else begin
        RegWriteE <= RegWriteD;
        MemtoRegE <= MemtoRegD;
        PCSrcE    <= PCSrcD;
        BranchE   <= BranchD;
      end
      // A failed condition squashes the architectural side effects in M.
      RegWriteM <= RegWriteE & CondExE;
      PCSrcM    <= PCSrcE & CondExE;
      MemtoRegM <= MemtoRegE;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      PCSrcW    <= PCSrcM;
    end
  end

  // Combinational outputs are masked so nothing leaks from live inputs during reset.
  assign ForwardAE    = reset ? fwd_a : 2'b00;
  assign ForwardBE    = reset ? fwd_b : 2'b00;
  assign StallF       = reset & (LDRstall | PCWrPendingF);
  assign StallD       = reset & LDRstall;
  assign FlushD       = reset & flush_d_raw;
  assign FlushE       = reset & flush_e_raw;
  assign BranchTakenE = reset & branch_taken;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LdStallCnt <= 16'h0000;
      FlushCnt   <= 16'h0000;
    end else begin
      if (LDRstall && (LdStallCnt != 16'hFFFF))
        LdStallCnt <= LdStallCnt + 16'd1;
      if ((flush_e_raw || flush_d_raw) && (FlushCnt != 16'hFFFF))
        FlushCnt <= FlushCnt + 16'd1;
    end
  end
`else
  assign LdStallCnt = 16'h0000;
  assign FlushCnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, PC write, branch and mid-run reset.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        RegWriteD, MemtoRegD, PCSrcD, BranchD, CondExE;
  logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, BranchTakenE;
  logic        RegWriteW, MemtoRegW, PCSrcW;
  logic [15:0] LdStallCnt, FlushCnt;

  int assertCount = 0;
  int failCount   = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [9:0] RW  = 10'b10_0000_0000;
  localparam logic [9:0] MR  = 10'b01_0000_0000;
  localparam logic [9:0] PD  = 10'b00_1000_0000;
  localparam logic [9:0] BD  = 10'b00_0100_0000;
  localparam logic [9:0] CX  = 10'b00_0010_0000;
  localparam logic [9:0] M1M = 10'b00_0001_0000;
  localparam logic [9:0] M1W = 10'b00_0000_1000;
  localparam logic [9:0] M2M = 10'b00_0000_0100;
  localparam logic [9:0] M2W = 10'b00_0000_0010;
  localparam logic [9:0] M12 = 10'b00_0000_0001;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .CondExE(CondExE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .BranchTakenE(BranchTakenE),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .LdStallCnt(LdStallCnt), .FlushCnt(FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setInputs(input logic [9:0] v);
    {RegWriteD, MemtoRegD, PCSrcD, BranchD, CondExE,
     Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = v;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic [9:0] v);
    @(negedge clk);
    setInputs(v);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    setInputs(PD | BD | CX | M1M | M2M | M12);
    #2;
    checkOutput("rst_StallF", StallF, 0);
    checkOutput("rst_FlushD", FlushD, 0);
    checkOutput("rst_FlushE", FlushE, 0);
    checkOutput("rst_ForwardAE", ForwardAE, 0);
    checkOutput("rst_PCSrcW", PCSrcW, 0);
    checkOutput("rst_FlushCnt", FlushCnt, 0);

    applyStimulus(10'b0);
    reset = 1'b1;

    // ALU forwarding from M then from W
    applyStimulus(RW);
    applyStimulus(CX);
    applyStimulus(M1M);
    checkOutput("fwdA_M", ForwardAE, 2'b10);
    applyStimulus(M1W);
    checkOutput("fwdA_W", ForwardAE, 2'b01);
    applyStimulus(M1W);
    checkOutput("fwdA_none", ForwardAE, 2'b00);

    // Both M and W match: M wins
    applyStimulus(RW | CX);
    applyStimulus(RW | CX);
    applyStimulus(CX);
    applyStimulus(M2M | M2W);
    checkOutput("fwdB_prio", ForwardBE, 2'b10);
    checkOutput("prio_RegWriteW", RegWriteW, 1);
    applyStimulus(M2M | M2W);
    checkOutput("fwdB_W", ForwardBE, 2'b01);
    applyStimulus(10'b0);

    // Load-use: one-cycle stall with one bubble
    applyStimulus(RW | MR);
    checkOutput("ld_pre_StallD", StallD, 0);
    applyStimulus(M12);
    checkOutput("ld_StallF", StallF, 1);
    checkOutput("ld_StallD", StallD, 1);
    checkOutput("ld_FlushE", FlushE, 1);
    checkOutput("ld_FlushD", FlushD, 0);
    applyStimulus(M12);
    checkOutput("ld_post_StallF", StallF, 0);
    checkOutput("ld_post_StallD", StallD, 0);
    checkOutput("ld_post_FlushE", FlushE, 0);
    checkOutput("ld_LdStallCnt", LdStallCnt, PERF ? 16'd1 : 16'd0);

    // PC write with condition passing
    applyStimulus(PD | CX);
    checkOutput("pc0_StallF", StallF, 1);
    checkOutput("pc0_FlushD", FlushD, 1);
    applyStimulus(CX);
    checkOutput("pc1_StallF", StallF, 1);
    checkOutput("pc1_FlushD", FlushD, 1);
    applyStimulus(CX);
    checkOutput("pc2_StallF", StallF, 1);
    checkOutput("pc2_FlushD", FlushD, 1);
    checkOutput("pc2_PCSrcW", PCSrcW, 0);
    applyStimulus(CX);
    checkOutput("pc3_StallF", StallF, 0);
    checkOutput("pc3_FlushD", FlushD, 1);
    checkOutput("pc3_PCSrcW", PCSrcW, 1);
    applyStimulus(CX);
    checkOutput("pc4_FlushD", FlushD, 0);
    checkOutput("pc4_PCSrcW", PCSrcW, 0);
    checkOutput("pc4_FlushCnt", FlushCnt, PERF ? 16'd5 : 16'd0);

    // PC write with condition failing: never reaches W
    applyStimulus(PD);
    checkOutput("pcn0_StallF", StallF, 1);
    applyStimulus(10'b0);
    checkOutput("pcn1_StallF", StallF, 1);
    applyStimulus(10'b0);
    checkOutput("pcn2_StallF", StallF, 0);
    checkOutput("pcn2_PCSrcW", PCSrcW, 0);
    applyStimulus(10'b0);
    checkOutput("pcn3_PCSrcW", PCSrcW, 0);

    // Taken branch
    applyStimulus(BD);
    checkOutput("br0_Taken", BranchTakenE, 0);
    applyStimulus(CX);
    checkOutput("br1_Taken", BranchTakenE, 1);
    checkOutput("br1_FlushD", FlushD, 1);
    checkOutput("br1_FlushE", FlushE, 1);
    checkOutput("br1_StallD", StallD, 0);
    applyStimulus(CX);
    checkOutput("br2_Taken", BranchTakenE, 0);
    checkOutput("br2_FlushE", FlushE, 0);

    // Branch taken and load-use in the same cycle
    applyStimulus(BD | RW | MR);
    applyStimulus(CX | M12);
    checkOutput("brld_FlushE", FlushE, 1);
    checkOutput("brld_FlushD", FlushD, 1);
    checkOutput("brld_StallD", StallD, 1);
    checkOutput("brld_StallF", StallF, 1);
    applyStimulus(10'b0);
    checkOutput("brld_post_StallD", StallD, 0);
    checkOutput("brld_LdStallCnt", LdStallCnt, PERF ? 16'd2 : 16'd0);
    checkOutput("brld_FlushCnt", FlushCnt, PERF ? 16'd9 : 16'd0);

    // Reset asserted between edges with a PC write sitting in M
    applyStimulus(PD | CX);
    applyStimulus(CX);
    applyStimulus(PD | BD | CX | M1M | M2M);
    checkOutput("mid_pre_StallF", StallF, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_StallF", StallF, 0);
    checkOutput("mid_StallD", StallD, 0);
    checkOutput("mid_FlushD", FlushD, 0);
    checkOutput("mid_FlushE", FlushE, 0);
    checkOutput("mid_Taken", BranchTakenE, 0);
    checkOutput("mid_ForwardAE", ForwardAE, 0);
    checkOutput("mid_ForwardBE", ForwardBE, 0);
    checkOutput("mid_PCSrcW", PCSrcW, 0);
    checkOutput("mid_LdStallCnt", LdStallCnt, 0);
    checkOutput("mid_FlushCnt", FlushCnt, 0);
    applyStimulus(10'b0);
    reset = 1'b1;
    applyStimulus(10'b0);
    checkOutput("post_PCSrcW0", PCSrcW, 0);
    checkOutput("post_StallF", StallF, 0);
    applyStimulus(10'b0);
    checkOutput("post_PCSrcW1", PCSrcW, 0);
    checkOutput("post_FlushCnt", FlushCnt, 0);
    applyStimulus(10'b0);
    checkOutput("post_PCSrcW2", PCSrcW, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
